writeback_unit: RTL
===================

# writeback_unit

Final pipeline stage of the single-cycle-derived core. It accepts completed instructions from execute, performs the data-memory access for loads and stores over a valid/ready request and response interface, and aligns and extends load data. It then drives the register-file write port (`reg_wr`, `address_wr`, `wb_out`), so it is the writer side of the register-file interface that decode reads. It stalls upstream while a memory transaction is outstanding.

## Interface
- `width`, 32, datapath width, taken from the shared package.
- `clk`  in  1  clock; all state on posedge.
- `reset`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  execute presents an instruction.
- `in_ready`  out  1  unit can accept; a transfer occurs when `in_valid && in_ready`.
- `opcode`  in  7  instruction opcode, using the package opcode constants.
- `func3`  in  3  load/store size and signedness.
- `rd`  in  5  destination register.
- `alu_result`  in  width  ALU result; this is the effective address for loads and stores.
- `pc_plus4`  in  width  link value for JAL/JALR.
- `csr_rdata`  in  width  CSR read value.
- `store_data`  in  width  rs2 value for stores.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  width  word-aligned address, `{alu_result[width-1:2],2'b00}`.
- `mem_req_we`  out  1  1 = store.
- `mem_req_wdata`  out  width  store data replicated to the lane.
- `mem_req_be`  out  4  byte enables.
- `mem_rsp_valid`  in  1  load data returned; no ready, the unit always sinks it.
- `mem_rsp_rdata`  in  width  raw 32-bit word.
- `reg_wr`  out  1  register-file write enable, one-cycle pulse.
- `address_wr`  out  5  write address.
- `wb_out`  out  width  write data.
- `misalign`  out  1  one-cycle pulse: misaligned load or store was dropped.

## Operation
- **States:** IDLE, REQ, WAIT.
  - `in_ready` = 1 only in IDLE.
- **Non-memory op accepted in IDLE** (R/I-type, LUI, AUIPC, JAL, JALR, CSR):
  - Source select: `alu_result`; `pc_plus4` for JAL/JALR; `csr_rdata` for CSR.
  - Next cycle: `reg_wr`=1, `address_wr`=`rd`, `wb_out`=selected source. State stays IDLE.
- **Load or store accepted:**
  - Latch address, `func3`, `rd`, data; go to REQ.
- **REQ:**
  - Hold `mem_req_valid`=1 and all request fields stable until `mem_req_ready`.
  - On handshake: store → IDLE; load → WAIT.
- **WAIT:**
  - On `mem_rsp_valid`, select the lane by `addr[1:0]`.
  - Extend per `func3`: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Next cycle pulse `reg_wr` with the result; go to IDLE.
- **Byte enables:**
  - SB: `4'b0001<<addr[1:0]`.
  - SH: `4'b0011<<addr[1:0]`.
  - SW: `4'b1111`.
  - `mem_req_wdata` carries the byte replicated ×4 for SB and the half replicated ×2 for SH.
- **Misalignment:** half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - No request is issued and no write occurs.
  - `misalign` pulses the next cycle; state stays IDLE.
- **rd = 0:** `reg_wr` is never asserted. For a load with rd = 0 the memory access still completes.
- **Branches, and stores after completion:** no register write.
- **Reset values:** all outputs 0; state IDLE.
  - Reset mid-transaction abandons the transaction.
  - A `mem_rsp_valid` arriving in IDLE or REQ is ignored.

## Timing
- Non-memory: accept at cycle N → `reg_wr` high during N+1 only. Back-to-back throughput is 1 per cycle.
- Load: accept at N → `mem_req_valid` from N+1.
  - Handshake at cycle M ≥ N+1.
  - Response at K ≥ M+1.
  - `reg_wr` at K+1; `in_ready` returns to 1 in K+1.
- Store: accept at N → request from N+1; handshake at M; `in_ready`=1 at M+1.
- The register file commits on the negative edge inside the `reg_wr` cycle. No bypass is required from this unit.
- Zero-cycle response (same cycle as the request handshake) is not supported; memory guarantees K ≥ M+1.

## Structure
- **Shared package:** `width`, the opcode constants, a `wb_state_t` enum (IDLE/REQ/WAIT), and a `ld_st_size_t` encoding for `func3` values.
- **Sub-module:** `load_align` (combinational: raw word, `addr[1:0]`, `func3` → extended data). It is reused by any future cache fill path.
- **Main module:** FSM, request registers, and write-port registers.

## Test plan
- **ADDI result:** `alu_result`=0x0000_002A, `rd`=5 → next cycle `reg_wr`=1, `address_wr`=5, `wb_out`=0x2A; `reg_wr`=0 the following cycle.
- **LB signed, delayed ready:** `alu_result`=0x1003, `mem_req_ready` delayed 3 cycles, rsp word 0x80FF_1234 → `mem_req_addr`=0x1000 held stable while waiting; `wb_out`=0xFFFF_FF80.
- **LHU and LW:** LHU at addr 0x2002 with rsp 0xBEEF_0000 → `wb_out`=0x0000_BEEF; LW rd=0 → access occurs, `reg_wr` stays 0.
- **SB:** SB at 0x3001, `store_data`=0x0000_00AB → `mem_req_be`=0010, `wdata`=0xABAB_ABAB, `we`=1, no `reg_wr`.
- **Misaligned:** LW at 0x4002 → no `mem_req_valid`, `misalign` pulse, `in_ready` stays 1.
- **Reset in WAIT:** reset asserted in WAIT → all outputs 0 immediately; a later `mem_rsp_valid` produces no write.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared types and constants for the writeback stage
// Provides datapath width, opcode constants, FSM state enum and load/store size encoding.
package writeback_unit_pkg;

  localparam int width = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } wb_state_t;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } ld_st_size_t;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - data-memory request/response bus
// master: the writeback unit (drives requests, sinks responses); slave: the memory.
interface writeback_unit_if
  import writeback_unit_pkg::*;
();
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [width-1:0] mem_req_addr;
  logic             mem_req_we;
  logic [width-1:0] mem_req_wdata;
  logic [3:0]       mem_req_be;
  logic             mem_rsp_valid;
  logic [width-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - lane select and sign/zero extension of load data
// Ports: raw (memory word), offset (addr[1:0]), func3 (size/signedness) -> data (extended).
module load_align
  import writeback_unit_pkg::*;
(
  input  logic [width-1:0] raw,
  input  logic [1:0]       offset,
  input  logic [2:0]       func3,
  output logic [width-1:0] data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = raw[{offset, 3'b000} +: 8];
    // Halves are only reached aligned, so offset[1] alone picks the lane.
    lane_h = offset[1] ? raw[31:16] : raw[15:0];
    case (func3)
      SZ_B:    data = {{24{lane_b[7]}}, lane_b};
      SZ_BU:   data = {24'd0, lane_b};
      SZ_H:    data = {{16{lane_h[15]}}, lane_h};
      SZ_HU:   data = {16'd0, lane_h};
      default: data = raw;
    endcase
  end
endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - final pipeline stage: memory access and register-file write port
// Ports: clk, reset (async active-low); execute handshake in_valid/in_ready with
// opcode/func3/rd/alu_result/pc_plus4/csr_rdata/store_data; mem (memory bus master);
// register write port reg_wr/address_wr/wb_out; misalign pulse.
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [4:0]          rd,
  input  logic [width-1:0]    alu_result,
  input  logic [width-1:0]    pc_plus4,
  input  logic [width-1:0]    csr_rdata,
  input  logic [width-1:0]    store_data,
  writeback_unit_if.master    mem,
  output logic                reg_wr,
  output logic [4:0]          address_wr,
  output logic [width-1:0]    wb_out,
  output logic                misalign
);
  wb_state_t        state, state_next;
  logic [width-1:0] req_addr, req_wdata, load_data, src_sel, wdata_c;
  logic [3:0]       req_be, be_c;
  logic [1:0]       req_off;
  logic [2:0]       req_f3;
  logic [4:0]       req_rd;
  logic             req_we;
  logic             accept, is_load, is_store, is_mem, writes_rd, misaligned;

  // in_ready is forced low while reset is held so every output reads 0 in reset.
  assign in_ready   = reset && (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign is_load    = (opcode == OP_LOAD);
  assign is_store   = (opcode == OP_STORE);
  assign is_mem     = is_load || is_store;
  assign writes_rd  = (opcode == OP_REG) || (opcode == OP_IMM) || (opcode == OP_LUI) ||
                      (opcode == OP_AUIPC) || (opcode == OP_JAL) || (opcode == OP_JALR) ||
                      (opcode == OP_SYSTEM);
  // func3[1:0]: 00 byte, 01 half, anything else handled as a word.
  assign misaligned = (func3[1:0] == 2'b01) ? alu_result[0] :
                      (func3[1:0] == 2'b00) ? 1'b0 : (alu_result[1:0] != 2'b00);

  always_comb begin
    src_sel = alu_result;
    if (opcode == OP_JAL || opcode == OP_JALR) src_sel = pc_plus4;
    else if (opcode == OP_SYSTEM)              src_sel = csr_rdata;
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (func3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << alu_result[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << alu_result[1:0];
        wdata_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .raw    (mem.mem_rsp_rdata),
    .offset (req_off),
    .func3  (req_f3),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem && !misaligned) state_next = REQ;
      REQ:     if (mem.mem_req_ready) state_next = req_we ? IDLE : WAIT;
      WAIT:    if (mem.mem_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr   <= '0;
      req_wdata  <= '0;
      req_be     <= '0;
      req_off    <= '0;
      req_f3     <= '0;
      req_rd     <= '0;
      req_we     <= 1'b0;
      reg_wr     <= 1'b0;
      address_wr <= '0;
      wb_out     <= '0;
      misalign   <= 1'b0;
    end else begin
      reg_wr   <= 1'b0;
      misalign <= 1'b0;
      if (accept) begin
        if (is_mem) begin
          if (misaligned) begin
            misalign <= 1'b1;
          end else begin
            req_addr  <= {alu_result[width-1:2], 2'b00};
            req_off   <= alu_result[1:0];
            req_f3    <= func3;
            req_rd    <= rd;
            req_we    <= is_store;
            req_be    <= be_c;
            req_wdata <= wdata_c;
          end
        end else if (writes_rd) begin
          reg_wr     <= (rd != 5'd0);
          address_wr <= rd;
          wb_out     <= src_sel;
        end
      end
      if (state == WAIT && mem.mem_rsp_valid) begin
        reg_wr     <= (req_rd != 5'd0);
        address_wr <= req_rd;
        wb_out     <= load_data;
      end
    end
  end

  assign mem.mem_req_valid = (state == REQ);
  assign mem.mem_req_addr  = req_addr;
  assign mem.mem_req_we    = req_we;
  assign mem.mem_req_wdata = req_wdata;
  assign mem.mem_req_be    = req_be;
endmodule
